// File: rtl/imem_loader.sv
// Boot loader: turns a UART byte image (sync, 16-bit word count, payload) into
// sequential instruction-memory word writes. Define IMEM_LOADER_CHECKSUM_EN for a trailing XOR check byte.
`timescale 1ns/1ps
module imem_loader #(
  parameter int         ADDR_W      = 12,
  parameter int         DEPTH_WORDS = 512,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERR} state_t;
  localparam state_t PAYLOAD_END = CHK;
  logic [7:0] xor_q;
`else
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, DONE, ERR} state_t;
  localparam state_t PAYLOAD_END = DONE;
`endif

  state_t            state_q, state_d;
  logic              armed;
  logic [1:0]        byte_cnt;
  logic [ADDR_W-3:0] word_idx;
  logic [15:0]       len_q;
  logic [23:0]       word_buf;
  logic              accept;
  logic              last_word;
  logic [15:0]       len_full;
  logic [15:0]       idx_next;

  // armed keeps rx_ready low for the first cycle after reset is released
  assign rx_ready  = armed && (state_q != DONE) && (state_q != ERR);
  assign accept    = rx_valid && rx_ready;
  assign len_full  = {rx_data, len_q[7:0]};
  assign idx_next  = 16'(word_idx) + 16'd1;
  assign last_word = (byte_cnt == 2'd3) && (idx_next == len_q);
  assign cpu_hold  = (state_q != DONE);
  assign load_done = (state_q == DONE);
  assign load_err  = (state_q == ERR);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (accept && rx_data == SYNC_BYTE) state_d = LEN_LO;
      LEN_LO: if (accept) state_d = LEN_HI;
      LEN_HI: begin
        if (accept) begin
          if (len_full == 16'd0)                   state_d = PAYLOAD_END;
          else if (len_full > 16'(DEPTH_WORDS))    state_d = ERR;
          else                                     state_d = DATA;
        end
      end
      DATA:   if (accept && last_word) state_d = PAYLOAD_END;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK:    if (accept) state_d = (rx_data == xor_q) ? DONE : ERR;
`endif
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      armed      <= 1'b0;
      byte_cnt   <= 2'd0;
      word_idx   <= '0;
      len_q      <= 16'd0;
      word_buf   <= 24'd0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q      <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      armed   <= 1'b1;
      imem_we <= 1'b0;
      if (accept) begin
        case (state_q)
          LEN_LO: len_q[7:0] <= rx_data;
          LEN_HI: begin
            len_q[15:8] <= rx_data;
            byte_cnt    <= 2'd0;
            word_idx    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q       <= 8'd0;
`endif
          end
          DATA: begin
            byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q    <= xor_q ^ rx_data;
`endif
            // little-endian assembly; the 4th byte goes straight into the write
            case (byte_cnt)
              2'd0: word_buf[7:0]   <= rx_data;
              2'd1: word_buf[15:8]  <= rx_data;
              2'd2: word_buf[23:16] <= rx_data;
              default: begin
                imem_we    <= 1'b1;
                imem_addr  <= {word_idx, 2'b00};
                imem_wdata <= {rx_data, word_buf};
                word_idx   <= word_idx + (ADDR_W-2)'(1);
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader: byte frames are checked against a
// stream-level model of the image format (sync, length, little-endian words).
`timescale 1ns/1ps
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        imem_we;
  logic [11:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold, load_done, load_err;

  always #5 clk = ~clk;

  imem_loader dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .load_done(load_done),
    .load_err(load_err)
  );

  typedef struct packed {logic [11:0] a; logic [31:0] d;} wr_t;
  wr_t        got_wr[$];
  wr_t        exp_wr[$];
  logic [7:0] stim[$];
  int vectors = 0, miscompares = 0;
  int adj_cnt = 0, acc_n = 0;
  int exp_status = 0, exp_consumed = 0;   // status 0 busy, 1 done, 2 error
  logic prev_we = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (imem_we) got_wr.push_back({imem_addr, imem_wdata});
    if (imem_we && prev_we) adj_cnt++;
    prev_we = imem_we;
  end

  // Reference: locate sync, read length, slice payload into 4-byte words.
  function automatic void model();
    int i, p, len, n;
    logic [7:0] x;
    exp_wr.delete();
    exp_status = 0;
    n = stim.size();
    i = 0;
    while (i < n && stim[i] != 8'hA5) i++;
    if (i + 3 > n) begin exp_consumed = n; return; end
    len = int'({stim[i+2], stim[i+1]});
    p = i + 3;
    exp_consumed = p;
    if (len > 512) begin exp_status = 2; return; end
    x = 8'd0;
    for (int w = 0; w < len; w++) begin
      if (p + 4*w + 4 > n) begin exp_consumed = n; return; end
      exp_wr.push_back({12'(4*w), stim[p+4*w+3], stim[p+4*w+2], stim[p+4*w+1], stim[p+4*w]});
      x = x ^ stim[p+4*w] ^ stim[p+4*w+1] ^ stim[p+4*w+2] ^ stim[p+4*w+3];
    end
    exp_consumed = p + 4*len;
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (exp_consumed >= n) return;
    exp_status = (stim[exp_consumed] == x) ? 1 : 2;
    exp_consumed++;
`else
    exp_status = 1;
`endif
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap, output bit acc);
    repeat (gap) @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (rx_ready) begin acc = 1'b1; break; end
      @(negedge clk);
    end
    if (acc) begin
      @(posedge clk);
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_range(input int maxgap, input int first, input int last);
    bit acc;
    for (int i = first; i < last; i++) begin
      send_byte(stim[i], $urandom_range(0, maxgap), acc);
      acc_n += int'(acc);
    end
  endtask

  task automatic do_reset(input bit chk_vals);
    @(negedge clk);
    reset_n = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    if (chk_vals) begin
      check("rst_we", imem_we, 0);
      check("rst_addr", imem_addr, 0);
      check("rst_wdata", imem_wdata, 0);
      check("rst_hold", cpu_hold, 1);
      check("rst_done", load_done, 0);
      check("rst_err", load_err, 0);
      check("rst_ready", rx_ready, 0);
    end
    reset_n = 1'b1;
    got_wr.delete();
    adj_cnt = 0;
    acc_n = 0;
    @(negedge clk);
    if (chk_vals) check("rst_ready_after", rx_ready, 1);
  endtask

  task automatic verify(input string tag);
    repeat (3) @(negedge clk);
    check({tag, "_accepted"}, acc_n, exp_consumed);
    check({tag, "_nwrites"}, got_wr.size(), exp_wr.size());
    for (int k = 0; k < exp_wr.size(); k++) begin
      check({tag, "_addr"}, (k < got_wr.size()) ? got_wr[k].a : 12'hxxx, exp_wr[k].a);
      check({tag, "_data"}, (k < got_wr.size()) ? got_wr[k].d : 32'hxxxxxxxx, exp_wr[k].d);
    end
    check({tag, "_done"}, load_done, exp_status == 1);
    check({tag, "_err"}, load_err, exp_status == 2);
    check({tag, "_hold"}, cpu_hold, exp_status != 1);
    check({tag, "_ready"}, rx_ready, exp_status == 0);
    check({tag, "_adjacent_we"}, adj_cnt, 0);
  endtask

  task automatic run_frame(input int maxgap, input string tag);
    model();
    send_range(maxgap, 0, stim.size());
    verify(tag);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int len;
    do_reset(1);

    // two-word image
    stim = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h05, 8'h00, 8'h20};
    run_frame(0, "t1");
    check("t1_w0_data", (got_wr.size() > 0) ? got_wr[0].d : 32'hxxxxxxxx, 32'h00000013);
    check("t1_w1_addr", (got_wr.size() > 1) ? got_wr[1].a : 12'hxxx, 12'h004);
    check("t1_w1_data", (got_wr.size() > 1) ? got_wr[1].d : 32'hxxxxxxxx, 32'h200005B7);

    // leading junk, gappy valid, write timing
    do_reset(0);
    stim = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h6F, 8'hF0, 8'h9F, 8'hFF};
    model();
    send_range(3, 0, stim.size() - 1);
    check("t2_we_before", imem_we, 0);
    send_range(3, stim.size() - 1, stim.size());
    check("t2_we_timing", imem_we, 1);
    check("t2_wdata_timing", imem_wdata, 32'hFF9FF06F);
    verify("t2");

    // oversize length, trailing bytes refused
    do_reset(0);
    stim = '{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22};
    run_frame(1, "t3");

    // empty image
    do_reset(0);
    stim = '{8'hA5, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stim.push_back(8'h00);
    run_frame(0, "t4");
    do_reset(0);
    stim = '{8'hA5, 8'h00, 8'h00, 8'h01};
    run_frame(0, "t4_badsum");
`else
    run_frame(0, "t4");
`endif

    // full-depth image, back-to-back
    do_reset(0);
    stim = '{8'hA5, 8'h00, 8'h02};
    for (int i = 0; i < 512; i++) begin
      stim.push_back(8'(i));
      stim.push_back(8'(i >> 8));
      stim.push_back(8'h00);
      stim.push_back(8'h00);
    end
    run_frame(0, "t5");
    check("t5_last_addr", (got_wr.size() == 512) ? got_wr[511].a : 12'hxxx, 12'h7FC);
    check("t5_last_data", (got_wr.size() == 512) ? got_wr[511].d : 32'hxxxxxxxx, 32'h000001FF);

    // reset in the middle of a frame
    do_reset(0);
    stim = '{8'hA5, 8'h04, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34};
    run_frame(0, "t6_part");
    do_reset(1);
    stim = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    run_frame(2, "t6_fresh");
    check("t6_fresh_data", (got_wr.size() > 0) ? got_wr[0].d : 32'hxxxxxxxx, 32'h12345678);

    // random frames
    for (int f = 0; f < 8; f++) begin
      do_reset(0);
      stim.delete();
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        stim.push_back(b);
      end
      len = ($urandom_range(0, 5) == 0) ? $urandom_range(513, 700) : $urandom_range(1, 6);
      stim.push_back(8'hA5);
      stim.push_back(8'(len));
      stim.push_back(8'(len >> 8));
      if (len <= 512) for (int k = 0; k < 4*len; k++) stim.push_back(8'($urandom));
      for (int t = $urandom_range(0, 2); t > 0; t--) stim.push_back(8'($urandom));
      run_frame(2, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time writer for the core's 512-word instruction memory, the counterpart of the instruction-fetch read port.
- Consumes a byte stream from the UART receiver: sync byte, 16-bit word count, payload.
- Assembles little-endian 32-bit words and writes them sequentially from address 0.
- Holds the CPU in reset until the image is complete.

Parameters:
ADDR_W, 12, byte-address width of instruction memory (matches fetch port addr)
DEPTH_WORDS, 512, maximum loadable words
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous active-low reset
rx_data  input  8  received byte
rx_valid  input  1  rx_data valid; byte accepted when rx_valid && rx_ready
rx_ready  output  1  loader can accept a byte
imem_we  output  1  one-cycle word write strobe
imem_addr  output  ADDR_W  byte address of write, always word aligned (bits [1:0]=0)
imem_wdata  output  32  word to write
cpu_hold  output  1  keep core in reset while 1
load_done  output  1  image loaded, sticky until reset
load_err  output  1  protocol error, sticky until reset

Behaviour:
Reset is synchronous, active-low, sampled on rising clk.
- Reset values: rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, load_done=0, load_err=0.
- Internal state: FSM=IDLE, byte_cnt=0, word_idx=0, len=0.
- rx_ready becomes 1 the first cycle after reset deasserts.
- Reset mid-load aborts: no further writes, FSM returns to IDLE, already-written words remain in memory.

FSM states: IDLE, LEN_LO, LEN_HI, DATA, (CHK), DONE, ERR.
- IDLE: accepted byte == SYNC_BYTE -> LEN_LO. Any other byte is discarded; stay in IDLE.
- LEN_LO: len[7:0] = byte -> LEN_HI.
- LEN_HI: len[15:8] = byte, then:
  - full len == 0 -> DONE.
  - len > DEPTH_WORDS -> ERR.
  - otherwise -> DATA.
- DATA: byte k of each word goes to wdata[8k+7:8k] (k=0..3, little-endian). Accepting the 4th byte at cycle N:
  - cycle N+1: imem_we=1, imem_addr=word_idx<<2, imem_wdata=assembled word.
  - word_idx increments.
  - rx_ready stays 1, so a new byte may be accepted in the same cycle as the write.
- When word_idx reaches len after the write: -> DONE (or -> CHK if the optional feature is enabled).
- DONE: rx_ready=0, cpu_hold=0, load_done=1. Stays until reset.
- ERR: rx_ready=0, cpu_hold=1, load_err=1. Stays until reset.
- rx_ready=1 in IDLE, LEN_LO, LEN_HI, DATA, CHK.
- imem_we is never high for two consecutive cycles.
- imem_wdata and imem_addr hold their last value when imem_we=0.
- No write occurs outside DATA.
- A byte presented while rx_ready=0 is not consumed and has no effect.
- byte_cnt is 2 bits and wraps 3->0. word_idx is ADDR_W-2 bits wide; it never wraps because of the len check.
- len == DEPTH_WORDS (512) is legal: last write at addr 0x7FC.

Optional Feature:
Macro IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - Running XOR of all DATA bytes, cleared on entry to DATA.
  - After the last word, FSM enters CHK and accepts one byte.
  - Byte equal to running XOR -> DONE; mismatch -> ERR.
  - len == 0 goes to CHK with expected value 8'h00.
- Not defined: no CHK state. Last word -> DONE directly. No XOR logic present.

Test Plan:
1. Reset, then bytes A5 02 00 13 00 00 00 B7 05 00 20 -> exactly two writes: addr 0x000 data 0x00000013, then addr 0x004 data 0x200005B7. Then load_done=1, cpu_hold=0, rx_ready=0.
2. Bytes 00 FF A5 01 00 6F F0 9F FF with rx_valid gaps of 0-3 cycles -> leading 00 FF discarded. One write: addr 0x000 data 0xFF9FF06F, on the cycle after the 4th payload byte is accepted.
3. A5 01 02 (len=513) -> load_err=1, cpu_hold=1, no imem_we. Further bytes are not accepted.
4. A5 00 00 -> load_done=1 with zero writes (checksum build: also needs byte 00; byte 01 instead -> load_err=1).
5. Continuous back-to-back rx_valid for len=512 with payload word i = i -> 512 writes, last at addr 0x7FC data 0x000001FF. imem_we never high on adjacent cycles.
6. reset_n low for one cycle after 6 payload bytes of a len=4 frame -> one write seen (addr 0x000). Then all outputs return to reset values, and a fresh frame A5 01 00 … writes again at addr 0x000.
